// File: rtl/different_widths_fifo.sv
`default_nettype none
// ============================================================================
// Module   : different_widths_fifo
// Purpose  : Single-clock FIFO that accepts WIDTH_IN-bit words and delivers
//            them as WIDTH_OUT-bit slices, least-significant slice first.
//            Output data is registered: an accepted pop loads the next slice
//            into q, valid in the following cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH_IN  : push word width (integer multiple of WIDTH_OUT)
//   WIDTH_OUT : pop slice width
//   DEPTH     : capacity in WIDTH_IN words (power of 2, >= 2)
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   push      : write request, accepted when full=0
//   pop       : read request, accepted when empty=0
//   d         : write data (WIDTH_IN)
//   q         : registered read slice (WIDTH_OUT)
//   full      : fewer than one word's worth of free slice slots remain
//   empty     : no unread slices stored
// Optional build macro
//   DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN : adds sticky overflow / underflow
//   outputs (push while full / pop while empty), cleared only by rst.
// ============================================================================
module different_widths_fifo #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 4,
    parameter int DEPTH     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH_IN-1:0]  d,
    output logic [WIDTH_OUT-1:0] q,
    output logic                 full,
    output logic                 empty
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_RATIO = WIDTH_IN / WIDTH_OUT;
    localparam int c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_SW    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam int c_CAP   = DEPTH * c_RATIO;
    localparam int c_CW    = $clog2(c_CAP + 1);

    localparam logic [c_CW-1:0] c_RATIO_CNT  = c_CW'(c_RATIO);
    localparam logic [c_CW-1:0] c_FULL_THR   = c_CW'(c_CAP - c_RATIO);
    localparam logic [c_SW-1:0] c_LAST_SLICE = c_SW'(c_RATIO - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH_IN-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_word;
    logic [c_SW-1:0]      r_rd_slice;
    logic [c_CW-1:0]      r_count;
    logic [WIDTH_OUT-1:0] r_q;

    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic [c_CW-1:0]      w_count_nxt;
    logic [WIDTH_IN-1:0]  w_rd_word;
    logic [WIDTH_OUT-1:0] w_slices [c_RATIO];

    // ------------------------------------------------------------------------
    // Flags come straight from the registered slice count, so they always
    // describe the state left by the most recent edge.
    // ------------------------------------------------------------------------
    assign full      = (r_count > c_FULL_THR);
    assign empty     = (r_count == '0);
    assign q         = r_q;

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop  && !empty;

    // ------------------------------------------------------------------------
    // Word storage: written whole, no reset needed since the count gates
    // every read.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= d;
        end
    end

    // Split the word under the read pointer into its slices; slice 0 is the
    // least-significant one and leaves the FIFO first.
    assign w_rd_word = r_mem[r_rd_word];

    generate
        for (genvar gi = 0; gi < c_RATIO; gi++) begin : g_slice
            assign w_slices[gi] = w_rd_word[gi*WIDTH_OUT +: WIDTH_OUT];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Occupancy in slices: a push adds a whole word, a pop removes one slice.
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + c_RATIO_CNT;
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            2'b11:   w_count_nxt = r_count + c_RATIO_CNT - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers, count and output register. DEPTH is a power of 2, so the
    // word pointers wrap naturally at their bit width.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_word  <= '0;
            r_rd_slice <= '0;
            r_count    <= '0;
            r_q        <= '0;
        end else begin
            r_count <= w_count_nxt;

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end

            if (w_pop_ok) begin
                r_q <= w_slices[r_rd_slice];
                // Last slice of the word consumed: move on to the next word.
                if (r_rd_slice == c_LAST_SLICE) begin
                    r_rd_slice <= '0;
                    r_rd_word  <= r_rd_word + c_AW'(1);
                end else begin
                    r_rd_slice <= r_rd_slice + c_SW'(1);
                end
            end
        end
    end

`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
    // ------------------------------------------------------------------------
    // Sticky error flags: record any rejected request until the next reset.
    // ------------------------------------------------------------------------
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && full) begin
                r_overflow <= 1'b1;
            end
            if (pop && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_different_widths_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_different_widths_fifo
// Purpose  : Self-checking bench for different_widths_fifo (8-bit in, 4-bit
//            out, 64 words). A slice queue holds the expected output order;
//            every cycle compares q, full and empty against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_different_widths_fifo;

    localparam int WI    = 8;
    localparam int WO    = 4;
    localparam int DEPTH = 64;
    localparam int RATIO = WI / WO;
    localparam int CAP   = DEPTH * RATIO;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          push = 1'b0;
    logic          pop  = 1'b0;
    logic [WI-1:0] d    = '0;
    logic [WO-1:0] q;
    logic          full;
    logic          empty;
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected slices in output order, plus the expected held q value.
    logic [WO-1:0] sb [$];
    logic [WO-1:0] m_q   = '0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    different_widths_fifo #(
        .WIDTH_IN  (WI),
        .WIDTH_OUT (WO),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .d         (d),
        .q         (q),
        .full      (full),
        .empty     (empty)
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, update the model at the
    // rising edge, then check outputs at the next falling edge.
    task automatic cycle(input logic p, input logic r, input logic [WI-1:0] data);
        bit push_ok;
        bit pop_ok;
        push    = p;
        pop     = r;
        d       = data;
        push_ok = p && (sb.size() <= CAP - RATIO);
        pop_ok  = r && (sb.size() != 0);
        if (p && !push_ok) m_ovf = 1'b1;
        if (r && !pop_ok)  m_unf = 1'b1;
        @(posedge clk);
        if (pop_ok) m_q = sb.pop_front();
        if (push_ok) begin
            for (int k = 0; k < RATIO; k++) sb.push_back(data[k*WO +: WO]);
        end
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        chk("q",     32'(q),     32'(m_q));
        chk("full",  32'(full),  32'(sb.size() > CAP - RATIO));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`endif
    endtask

    initial begin
        logic [7:0]    w;
        logic [WO-1:0] nib;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_q",     32'(q),     32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full",  32'(full),  32'h0);

        // ---------------- single word ----------------
        cycle(1'b1, 1'b0, 8'h01);
        chk("one_push_empty", 32'(empty), 32'h0);
        chk("one_push_full",  32'(full),  32'h0);
        cycle(1'b0, 1'b1, '0);
        chk("one_pop_lo", 32'(q), 32'h1);
        cycle(1'b0, 1'b1, '0);
        chk("one_pop_hi", 32'(q), 32'h0);
        chk("one_drained_empty", 32'(empty), 32'h1);

        // ---------------- fill to full ----------------
        for (int i = 1; i <= 63; i++) cycle(1'b1, 1'b0, 8'(i));
        chk("full_after_63", 32'(full), 32'h0);
        cycle(1'b1, 1'b0, 8'd64);
        chk("full_after_64", 32'(full), 32'h1);
        cycle(1'b1, 1'b0, 8'hAA);   // must be dropped
        chk("full_after_65", 32'(full), 32'h1);
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
        chk("overflow_set", 32'(overflow), 32'h1);
`endif

        // ---------------- drain, checking nibble order ----------------
        for (int i = 0; i < 128; i++) begin
            cycle(1'b0, 1'b1, '0);
            w   = 8'(i / 2 + 1);
            nib = (i % 2 == 1) ? w[7:4] : w[3:0];
            chk("pop_seq", 32'(q), 32'(nib));
        end
        chk("drained_empty", 32'(empty), 32'h1);
        chk("drained_full",  32'(full),  32'h0);

        // ---------------- pop while empty ----------------
        cycle(1'b0, 1'b1, '0);
        chk("empty_pop_q",     32'(q),     32'h4);
        chk("empty_pop_empty", 32'(empty), 32'h1);
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
        chk("underflow_set", 32'(underflow), 32'h1);
`endif

        // ---------------- half-occupancy streaming across wrap ----------------
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b1, 8'($urandom));
            cycle(1'b0, 1'b1, '0);
        end
        chk("stream_no_full",  32'(full),  32'h0);
        chk("stream_no_empty", 32'(empty), 32'h0);

        // ---------------- mid-stream reset ----------------
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'($urandom));
        #2;
        rst = 1'b1;
        sb.delete();
        m_q   = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        chk("midrst_q",     32'(q),     32'h0);
        chk("midrst_empty", 32'(empty), 32'h1);
        chk("midrst_full",  32'(full),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, '0);
`ifdef DIFFERENT_WIDTHS_FIFO_ERR_FLAGS_EN
        chk("midrst_overflow",  32'(overflow),  32'h0);
        chk("midrst_underflow", 32'(underflow), 32'h0);
`endif
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b1, '0);
        chk("post_rst_lo", 32'(q), 32'hA);
        cycle(1'b0, 1'b1, '0);
        chk("post_rst_hi", 32'(q), 32'h5);
        chk("post_rst_empty", 32'(empty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
